// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch flushes, memory waits and mul/div sequencing.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module hazard_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_use,
   input  logic       id_rs2_use,
   input  logic       ex_valid,
   input  logic       ex_we,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   input  logic       ex_br_taken,
   input  logic       ex_mc_req,
   input  logic       mc_done,
   input  logic       mem_valid,
   input  logic       mem_we,
   input  logic [4:0] mem_rd,
   input  logic       mem_busy,
   output logic       stall_if,
   output logic       stall_id,
   output logic       stall_ex,
   output logic       stall_mem,
   output logic       bubble_ex,
   output logic       bubble_mem,
   output logic       flush_if,
   output logic       flush_id,
   output logic       mc_go,
   output logic [1:0] fwd_rs1_sel,
   output logic [1:0] fwd_rs2_sel
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   // state    | meaning
   // RUN      | normal issue; priority rules decide controls
   // MEM_WAIT | data memory busy, whole pipe frozen
   // MC_WAIT  | mul/div in flight, front end held until result can enter MEM
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MC_WAIT = 2'd2} state_t;

   state_t state_q, state_d;
   logic   lu;
   logic   mc_exit;

   // Loads are never forwarded from EX: their data only exists in MEM.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       exv, input logic exwe,
                                          input logic       exld, input logic [4:0] exrd,
                                          input logic       memv, input logic memwe,
                                          input logic [4:0] memrd);
      if (exv && exwe && !exld && (exrd == rs) && (rs != 5'd0))
         return 2'b01;
      else if (memv && memwe && (memrd == rs) && (rs != 5'd0))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   always_comb begin
      fwd_rs1_sel = fwd_sel(id_rs1, ex_valid, ex_we, ex_is_load, ex_rd, mem_valid, mem_we, mem_rd);
      fwd_rs2_sel = fwd_sel(id_rs2, ex_valid, ex_we, ex_is_load, ex_rd, mem_valid, mem_we, mem_rd);
   end

   assign lu = id_valid && ex_valid && ex_is_load && ex_we && (ex_rd != 5'd0) &&
               ((id_rs1_use && (id_rs1 == ex_rd)) || (id_rs2_use && (id_rs2 == ex_rd)));

   assign mc_exit = mc_done && !mem_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= RUN;
      else      state_q <= state_d;
   end

   // MEM_WAIT with mem_busy low behaves exactly like RUN, so release costs no cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (mem_busy)                    state_d = MEM_WAIT;
            else if (ex_valid && ex_mc_req)  state_d = MC_WAIT;
            else                             state_d = RUN;
         end
         MC_WAIT: if (mc_exit) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      stall_mem  = 1'b0;
      bubble_ex  = 1'b0;
      bubble_mem = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      mc_go      = 1'b0;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (mem_busy) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               stall_ex  = 1'b1;
               stall_mem = 1'b1;
            end else if (ex_valid && ex_mc_req) begin
               mc_go      = 1'b1;
               stall_if   = 1'b1;
               stall_id   = 1'b1;
               stall_ex   = 1'b1;
               bubble_mem = 1'b1;
            end else if (ex_br_taken) begin
               flush_if = 1'b1;
               flush_id = 1'b1;
            end else if (lu) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
            end
         end
         MC_WAIT: begin
            if (!mc_exit) begin
               stall_if   = 1'b1;
               stall_id   = 1'b1;
               stall_ex   = 1'b1;
               stall_mem  = mem_busy;
               bubble_mem = !mem_busy;
            end
         end
         default: ;
      endcase
      if (!rst) begin
         stall_if   = 1'b0;
         stall_id   = 1'b0;
         stall_ex   = 1'b0;
         stall_mem  = 1'b0;
         bubble_ex  = 1'b0;
         bubble_mem = 1'b0;
         flush_if   = 1'b0;
         flush_id   = 1'b0;
         mc_go      = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   assign stall_cnt_d = stall_cnt_q + {31'd0, stall_if};
   assign flush_cnt_d = flush_cnt_q + {31'd0, flush_if};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; inputs change on the falling edge, outputs are checked 1ns later.
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_rs1_use, id_rs2_use;
   logic [4:0] id_rs1, id_rs2;
   logic       ex_valid, ex_we, ex_is_load, ex_br_taken, ex_mc_req, mc_done;
   logic [4:0] ex_rd;
   logic       mem_valid, mem_we, mem_busy;
   logic [4:0] mem_rd;
   logic       stall_if, stall_id, stall_ex, stall_mem;
   logic       bubble_ex, bubble_mem, flush_if, flush_id, mc_go;
   logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
      .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_br_taken(ex_br_taken), .ex_mc_req(ex_mc_req), .mc_done(mc_done),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_busy(mem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush_if(flush_if), .flush_id(flush_id),
      .mc_go(mc_go), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   function automatic logic [8:0] ctl();
      return {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, flush_if, flush_id, mc_go};
   endfunction

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
      ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_br_taken = 0;
      ex_mc_req = 0; mc_done = 0;
      mem_valid = 0; mem_we = 0; mem_rd = 0; mem_busy = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); idle(); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0; mem_busy = 1; ex_valid = 1; ex_we = 1; ex_rd = 5'd5;
      ex_mc_req = 1; id_valid = 1; id_rs1 = 5'd5; id_rs1_use = 1;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 9'b0); end
      total++; if (fwd_rs1_sel !== 2'b01) begin bad++; $display("FAIL reset_fwd1 got=%b exp=01", fwd_rs1_sel); end
`ifdef HAZARD_PERF_CNT_EN
      total++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
`endif
      @(negedge clk); idle(); rst = 1'b1;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL reset_idle got=%b exp=%b", ctl(), 9'b0); end
   endtask

   task automatic test_forward();
      @(negedge clk); idle();
      ex_valid = 1; ex_we = 1; ex_rd = 5'd5; mem_valid = 1; mem_we = 1; mem_rd = 5'd0;
      id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd0; id_rs1_use = 1; id_rs2_use = 1;
      #1;
      total++; if (fwd_rs1_sel !== 2'b01) begin bad++; $display("FAIL fwd_ex_rs1 got=%b exp=01", fwd_rs1_sel); end
      total++; if (fwd_rs2_sel !== 2'b00) begin bad++; $display("FAIL fwd_x0_rs2 got=%b exp=00", fwd_rs2_sel); end
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL fwd_nostall got=%b exp=%b", ctl(), 9'b0); end
      @(negedge clk);
      mem_rd = 5'd7; ex_rd = 5'd8; id_rs1 = 5'd8; id_rs2 = 5'd7;
      #1;
      total++; if (fwd_rs2_sel !== 2'b10) begin bad++; $display("FAIL fwd_mem_rs2 got=%b exp=10", fwd_rs2_sel); end
      total++; if (fwd_rs1_sel !== 2'b01) begin bad++; $display("FAIL fwd_ex_rs1b got=%b exp=01", fwd_rs1_sel); end
      @(negedge clk);
      ex_rd = 5'd7; id_rs1 = 5'd3;
      #1;
      total++; if (fwd_rs2_sel !== 2'b01) begin bad++; $display("FAIL fwd_ex_priority got=%b exp=01", fwd_rs2_sel); end
      total++; if (fwd_rs1_sel !== 2'b00) begin bad++; $display("FAIL fwd_none got=%b exp=00", fwd_rs1_sel); end
      @(negedge clk);
      ex_we = 0;
      #1;
      total++; if (fwd_rs2_sel !== 2'b10) begin bad++; $display("FAIL fwd_ex_nowe got=%b exp=10", fwd_rs2_sel); end
      @(negedge clk);
      ex_we = 1; mem_valid = 0; id_rs2_use = 0; ex_rd = 5'd9; id_rs2 = 5'd9;
      #1;
      total++; if (fwd_rs2_sel !== 2'b01) begin bad++; $display("FAIL fwd_rs2_ex got=%b exp=01", fwd_rs2_sel); end
   endtask

   task automatic test_load_use();
      @(negedge clk); idle();
      ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 5'd3;
      id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd3; id_rs1_use = 1; id_rs2_use = 1;
      #1;
      total++; if (ctl() !== 9'b110010000) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctl(), 9'b110010000); end
      total++; if (fwd_rs2_sel !== 2'b00) begin bad++; $display("FAIL lu_nofwd_ex got=%b exp=00", fwd_rs2_sel); end
      @(negedge clk);
      ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0;
      mem_valid = 1; mem_we = 1; mem_rd = 5'd3;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL lu_after got=%b exp=%b", ctl(), 9'b0); end
      total++; if (fwd_rs2_sel !== 2'b10) begin bad++; $display("FAIL lu_mem_fwd got=%b exp=10", fwd_rs2_sel); end
      @(negedge clk); idle();
      ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 5'd0;
      id_valid = 1; id_rs1 = 5'd0; id_rs1_use = 1;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", ctl(), 9'b0); end
      @(negedge clk);
      ex_rd = 5'd4; id_rs1 = 5'd4; id_rs1_use = 0;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL lu_nouse got=%b exp=%b", ctl(), 9'b0); end
      @(negedge clk);
      id_rs1_use = 1;
      #1;
      total++; if (ctl() !== 9'b110010000) begin bad++; $display("FAIL lu_rs1 got=%b exp=%b", ctl(), 9'b110010000); end
      @(negedge clk);
      id_valid = 0;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL lu_idinv got=%b exp=%b", ctl(), 9'b0); end
   endtask

   task automatic test_branch();
      @(negedge clk); idle();
      ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 5'd3; ex_br_taken = 1;
      id_valid = 1; id_rs1 = 5'd3; id_rs1_use = 1;
      #1;
      total++; if (ctl() !== 9'b000000110) begin bad++; $display("FAIL br_flush got=%b exp=%b", ctl(), 9'b000000110); end
      @(negedge clk); idle();
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL br_once got=%b exp=%b", ctl(), 9'b0); end
   endtask

   task automatic test_mc_memwait();
      int go_cnt = 0;
      logic [8:0] exp;
      @(negedge clk); idle();
      for (int c = 0; c < 9; c++) begin
         if (c != 0) @(negedge clk);
         ex_valid = (c <= 7); ex_mc_req = (c <= 7);
         mc_done  = (c >= 4 && c <= 7); mem_busy = (c >= 4 && c <= 6);
         #1;
         exp = {c <= 6 ? 3'b111 : 3'b000, (c >= 4 && c <= 6), 1'b0, (c <= 3), 2'b00, (c == 0)};
         if (mc_go) go_cnt++;
         total++; if (ctl() !== exp) begin bad++; $display("FAIL mc_cycle%0d got=%b exp=%b", c, ctl(), exp); end
      end
      total++; if (go_cnt !== 1) begin bad++; $display("FAIL mc_go_count got=%0d exp=1", go_cnt); end
   endtask

   task automatic test_memwait_branch();
      logic [8:0] exp;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         ex_valid = (c <= 3); ex_br_taken = (c <= 3); mem_busy = (c <= 2);
         #1;
         exp = (c <= 2) ? 9'b111100000 : (c == 3) ? 9'b000000110 : 9'b0;
         total++; if (ctl() !== exp) begin bad++; $display("FAIL mwb_cycle%0d got=%b exp=%b", c, ctl(), exp); end
      end
`ifdef HAZARD_PERF_CNT_EN
      total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL cnt_stall got=%0d exp=3", stall_cycles); end
      total++; if (flush_count !== 32'd1) begin bad++; $display("FAIL cnt_flush got=%0d exp=1", flush_count); end
`endif
   endtask

   task automatic test_reset_in_mc();
      @(negedge clk); idle();
      ex_valid = 1; ex_mc_req = 1;
      @(negedge clk);
      #1;
      total++; if (ctl() !== 9'b111001000) begin bad++; $display("FAIL rmc_wait got=%b exp=%b", ctl(), 9'b111001000); end
      @(negedge clk); rst = 1'b0;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL rmc_rst got=%b exp=%b", ctl(), 9'b0); end
      @(negedge clk); rst = 1'b1;
      #1;
      total++; if (ctl() !== 9'b111001001) begin bad++; $display("FAIL rmc_restart got=%b exp=%b", ctl(), 9'b111001001); end
      @(negedge clk); idle();
      mem_busy = 1;
      @(negedge clk);
      mem_busy = 0; ex_valid = 1; ex_mc_req = 1; mc_done = 1;
      #1;
      total++; if (ctl() !== 9'b0) begin bad++; $display("FAIL rmc_exit got=%b exp=%b", ctl(), 9'b0); end
      @(negedge clk); idle();
      ex_valid = 1; ex_mc_req = 1; mem_busy = 1;
      #1;
      total++; if (ctl() !== 9'b111100000) begin bad++; $display("FAIL mc_behind_mem got=%b exp=%b", ctl(), 9'b111100000); end
      @(negedge clk);
      mem_busy = 0;
      #1;
      total++; if (ctl() !== 9'b111001001) begin bad++; $display("FAIL mc_after_mem got=%b exp=%b", ctl(), 9'b111001001); end
      @(negedge clk); idle();
   endtask

   initial begin
      idle();
      rst = 1'b0;
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_mc_memwait();
      test_memwait_branch();
      test_reset_in_mc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
